mips_regfile_param: RTL and testbench

- Parametrised successor to the 8x32 MIPS register file: configurable width and depth, two combinational read ports and one write port.
- Adds an asynchronous active-low reset that starts a sequential clear sweep, same-cycle write-to-read bypass, and a per-register busy scoreboard so the pipeline can detect pending writebacks.
- Sits between decode (read and reserve) and writeback (write) in the processor datapath.

---
 rtl/mips_regfile_param.sv | 150 +++++++++++++++
 tb/tb_mips_regfile_param.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_regfile_param.sv
`default_nettype none
// ============================================================================
//  Module   : mips_regfile_param
//  Purpose  : Parametrised MIPS register file. Two combinational read ports
//             with same-cycle write bypass, one write port, a per-register
//             busy scoreboard for pending writebacks, and a post-reset
//             sequential clear sweep that zeroes every entry.
//  Revision : 1.0  initial release
// ============================================================================
module mips_regfile_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] read_reg_1,
    input  logic [ADDR_W-1:0] read_reg_2,
    output logic [DATA_W-1:0] read_data_1,
    output logic [DATA_W-1:0] read_data_2,
    output logic              busy_1,
    output logic              busy_2,
    input  logic              signal_reg_write,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_reg,
    output logic              ready
);

    localparam int              c_DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_LAST_IDX = '1;
    localparam logic [ADDR_W-1:0] c_IDX_ZERO = '0;
    localparam bit              c_ZERO_EN  = (ZERO_REG != 0);

    // Controller states: sweep after reset, then normal operation forever
    localparam logic [0:0] c_CLEAR = 1'b0;
    localparam logic [0:0] c_RUN   = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_next;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic [c_DEPTH-1:0] r_busy;

    logic w_sweep_en;
    logic w_run;
    logic w_wr_en;
    logic w_rsv_en;

    // State register and clear counter; reset restarts the sweep at entry 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_sweep_en) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
        end
    end

    // Next state: leave CLEAR on the edge that clears the last entry
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_CLEAR: begin
                if (r_clr_cnt == c_LAST_IDX) begin
                    w_state_next = c_RUN;
                end
            end
            c_RUN:   w_state_next = c_RUN;
            default: w_state_next = c_CLEAR;
        endcase
    end

    // State decode; ready is the state flop itself, so it is glitch-free
    always_comb begin
        w_sweep_en = (r_state == c_CLEAR);
        w_run      = (r_state == c_RUN);
    end

    assign ready = w_run;

    // Writes and reserves only act in RUN; register 0 is immune when hardwired
    assign w_wr_en  = w_run && signal_reg_write
                      && !(c_ZERO_EN && (write_reg == c_IDX_ZERO));
    assign w_rsv_en = w_run && rsv_en
                      && !(c_ZERO_EN && (rsv_reg == c_IDX_ZERO));

    // Storage array: the sweep owns it in CLEAR, the write port in RUN
    always_ff @(posedge clk) begin
        if (w_sweep_en) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_wr_en) begin
            r_mem[write_reg] <= write_data;
        end
    end

    // Scoreboard: writeback clears, reserve sets; reserve is last so a new
    // producer of the same register keeps it busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            if (w_wr_en) begin
                r_busy[write_reg] <= 1'b0;
            end
            if (w_rsv_en) begin
                r_busy[rsv_reg] <= 1'b1;
            end
        end
    end

    // Read data for one port: zero reg, then bypass of the in-flight write,
    // then the array. Everything reads 0 until the sweep has finished.
    function automatic logic [DATA_W-1:0] f_rd_data(input logic [ADDR_W-1:0] idx);
        logic [DATA_W-1:0] v;
        v = '0;
        if (w_run && !(c_ZERO_EN && (idx == c_IDX_ZERO))) begin
            if (w_wr_en && (write_reg == idx)) begin
                v = write_data;
            end else begin
                v = r_mem[idx];
            end
        end
        return v;
    endfunction

    // Busy for one port: raw scoreboard bit, deliberately without bypass
    function automatic logic f_rd_busy(input logic [ADDR_W-1:0] idx);
        logic v;
        v = 1'b0;
        if (w_run && !(c_ZERO_EN && (idx == c_IDX_ZERO))) begin
            v = r_busy[idx];
        end
        return v;
    endfunction

    // Two independent combinational read ports
    always_comb begin
        read_data_1 = f_rd_data(read_reg_1);
        read_data_2 = f_rd_data(read_reg_2);
        busy_1      = f_rd_busy(read_reg_1);
        busy_2      = f_rd_busy(read_reg_2);
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_regfile_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mips_regfile_param
//  Purpose  : Directed self-checking bench for mips_regfile_param, covering
//             the default 32x8 configuration and a 16x16 instance without a
//             hardwired zero register.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mips_regfile_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Default instance (32-bit, 8 entries, zero register)
    logic        a_rst_n = 1'b0;
    logic [2:0]  a_rr1 = '0, a_rr2 = '0, a_wr = '0, a_rsv_reg = '0;
    logic [31:0] a_rd1, a_rd2, a_wd = '0;
    logic        a_b1, a_b2, a_we = 1'b0, a_rsv = 1'b0, a_ready;

    mips_regfile_param dut_a (
        .clk              (clk),
        .rst_n            (a_rst_n),
        .read_reg_1       (a_rr1),
        .read_reg_2       (a_rr2),
        .read_data_1      (a_rd1),
        .read_data_2      (a_rd2),
        .busy_1           (a_b1),
        .busy_2           (a_b2),
        .signal_reg_write (a_we),
        .write_reg        (a_wr),
        .write_data       (a_wd),
        .rsv_en           (a_rsv),
        .rsv_reg          (a_rsv_reg),
        .ready            (a_ready)
    );

    // Alternate instance (16-bit, 16 entries, register 0 ordinary)
    logic        b_rst_n = 1'b0;
    logic [3:0]  b_rr1 = '0, b_rr2 = '0, b_wr = '0, b_rsv_reg = '0;
    logic [15:0] b_rd1, b_rd2, b_wd = '0;
    logic        b_b1, b_b2, b_we = 1'b0, b_rsv = 1'b0, b_ready;

    mips_regfile_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0)) dut_b (
        .clk              (clk),
        .rst_n            (b_rst_n),
        .read_reg_1       (b_rr1),
        .read_reg_2       (b_rr2),
        .read_data_1      (b_rd1),
        .read_data_2      (b_rd2),
        .busy_1           (b_b1),
        .busy_2           (b_b2),
        .signal_reg_write (b_we),
        .write_reg        (b_wr),
        .write_data       (b_wd),
        .rsv_en           (b_rsv),
        .rsv_reg          (b_rsv_reg),
        .ready            (b_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after a rising edge; outputs are sampled on the falling edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        // ---------------- default instance: reset and sweep ----------------
        repeat (3) tick();
        smp();
        check("a_reset_ready", {31'b0, a_ready}, 32'h0);
        check("a_reset_rd1", a_rd1, 32'h0);
        tick();
        a_rst_n = 1'b1;
        // write attempt during the sweep must be dropped; bypass must not show it
        a_we = 1'b1; a_wr = 3'd3; a_wd = 32'hDEADBEEF; a_rr1 = 3'd3; a_rr2 = 3'd5;
        a_rsv = 1'b1; a_rsv_reg = 3'd5;
        for (int i = 0; i < 8; i++) begin
            smp();
            check($sformatf("a_sweep_ready_%0d", i), {31'b0, a_ready}, 32'h0);
            check($sformatf("a_sweep_rd1_%0d", i), a_rd1, 32'h0);
            check($sformatf("a_sweep_busy2_%0d", i), {31'b0, a_b2}, 32'h0);
            @(posedge clk);
        end
        #1;
        a_we = 1'b0; a_rsv = 1'b0;
        smp();
        check("a_ready_after_8", {31'b0, a_ready}, 32'h1);
        check("a_reg3_dropped", a_rd1, 32'h0);
        check("a_reg5_not_busy", {31'b0, a_b2}, 32'h0);

        // ---------------- write with bypass ----------------
        tick();
        a_we = 1'b1; a_wr = 3'd5; a_wd = 32'h12345678; a_rr1 = 3'd5;
        smp();
        check("a_bypass_rd1", a_rd1, 32'h12345678);
        tick();
        a_we = 1'b0;
        smp();
        check("a_stored_rd1", a_rd1, 32'h12345678);
        check("a_stored_busy1", {31'b0, a_b1}, 32'h0);

        // ---------------- zero register ----------------
        tick();
        a_we = 1'b1; a_wr = 3'd0; a_wd = 32'hFFFFFFFF; a_rsv = 1'b1; a_rsv_reg = 3'd0; a_rr1 = 3'd0;
        smp();
        check("a_zero_rd1_wcycle", a_rd1, 32'h0);
        check("a_zero_busy1_wcycle", {31'b0, a_b1}, 32'h0);
        tick();
        a_we = 1'b0; a_rsv = 1'b0;
        smp();
        check("a_zero_rd1_after", a_rd1, 32'h0);
        check("a_zero_busy1_after", {31'b0, a_b1}, 32'h0);

        // ---------------- scoreboard ----------------
        tick();
        a_rsv = 1'b1; a_rsv_reg = 3'd2; a_rr2 = 3'd2;
        smp();
        check("a_busy2_no_bypass", {31'b0, a_b2}, 32'h0);
        tick();
        a_rsv = 1'b0;
        smp();
        check("a_busy2_reserved", {31'b0, a_b2}, 32'h1);
        tick();
        a_we = 1'b1; a_wr = 3'd2; a_wd = 32'h000000A5;
        smp();
        check("a_rd2_bypass_a5", a_rd2, 32'h000000A5);
        check("a_busy2_still_set", {31'b0, a_b2}, 32'h1);
        tick();
        a_we = 1'b0;
        smp();
        check("a_busy2_cleared", {31'b0, a_b2}, 32'h0);
        check("a_rd2_a5", a_rd2, 32'h000000A5);

        // same-cycle write and reserve of reg 4: producer wins
        tick();
        a_we = 1'b1; a_wr = 3'd4; a_wd = 32'h00004444; a_rsv = 1'b1; a_rsv_reg = 3'd4; a_rr1 = 3'd4;
        tick();
        a_we = 1'b0; a_rsv = 1'b0;
        smp();
        check("a_same_busy1", {31'b0, a_b1}, 32'h1);
        check("a_same_rd1", a_rd1, 32'h00004444);

        // write reg 1 and reserve reg 3 together
        tick();
        a_we = 1'b1; a_wr = 3'd1; a_wd = 32'h00000011; a_rsv = 1'b1; a_rsv_reg = 3'd3;
        a_rr1 = 3'd1; a_rr2 = 3'd3;
        tick();
        a_we = 1'b0; a_rsv = 1'b0;
        smp();
        check("a_diff_rd1", a_rd1, 32'h00000011);
        check("a_diff_busy1", {31'b0, a_b1}, 32'h0);
        check("a_diff_busy2", {31'b0, a_b2}, 32'h1);

        // ---------------- mid-operation reset ----------------
        tick();
        a_we = 1'b1; a_wr = 3'd6; a_wd = 32'h00000055; a_rsv = 1'b1; a_rsv_reg = 3'd7;
        tick();
        a_we = 1'b0; a_rsv = 1'b0; a_rr1 = 3'd6; a_rr2 = 3'd7;
        smp();
        check("a_pre_rst_rd1", a_rd1, 32'h00000055);
        check("a_pre_rst_busy2", {31'b0, a_b2}, 32'h1);
        #2;
        a_rst_n = 1'b0;
        #1;
        check("a_async_ready", {31'b0, a_ready}, 32'h0);
        check("a_async_busy2", {31'b0, a_b2}, 32'h0);
        check("a_async_rd1", a_rd1, 32'h0);
        tick();
        tick();
        a_rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            smp();
            check($sformatf("a_resweep_ready_%0d", i), {31'b0, a_ready}, 32'h0);
            @(posedge clk);
        end
        #1;
        smp();
        check("a_resweep_done", {31'b0, a_ready}, 32'h1);
        check("a_reg6_cleared", a_rd1, 32'h0);
        check("a_reg7_not_busy", {31'b0, a_b2}, 32'h0);

        // ---------------- 16x16 instance without zero register ----------------
        tick();
        b_rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            smp();
            check($sformatf("b_sweep_ready_%0d", i), {31'b0, b_ready}, 32'h0);
            @(posedge clk);
        end
        #1;
        smp();
        check("b_ready_after_16", {31'b0, b_ready}, 32'h1);
        tick();
        b_we = 1'b1; b_wr = 4'd0; b_wd = 16'hBEEF; b_rr1 = 4'd0;
        smp();
        check("b_reg0_bypass", {16'b0, b_rd1}, 32'h0000BEEF);
        tick();
        b_we = 1'b0;
        smp();
        check("b_reg0_stored", {16'b0, b_rd1}, 32'h0000BEEF);
        tick();
        b_we = 1'b1; b_wr = 4'd15; b_wd = 16'h0F0F; b_rsv = 1'b1; b_rsv_reg = 4'd15; b_rr2 = 4'd15;
        tick();
        b_we = 1'b0; b_rsv = 1'b0;
        smp();
        check("b_reg15_data", {16'b0, b_rd2}, 32'h00000F0F);
        check("b_reg15_busy", {31'b0, b_b2}, 32'h1);
        tick();
        b_rsv = 1'b1; b_rsv_reg = 4'd0;
        tick();
        b_rsv = 1'b0;
        smp();
        check("b_reg0_reservable", {31'b0, b_b1}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
